mesh_config_sequencer: RTL and testbench

MESH_CONFIG_SEQUENCER -- requirements
Module: mesh_config_sequencer

---
 rtl/mesh_config_sequencer_pkg.sv | 27 ++
 rtl/mesh_config_sequencer_if.sv | 33 +++
 rtl/mesh_config_sequencer_seq_counter.sv | 35 +++
 rtl/mesh_config_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mesh_config_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_config_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mesh_pkg
// Shared definitions for the mesh configuration sequencer: FSM state
// encoding, PE opcode constants and default timing parameters.
// No ports (package).
// ----------------------------------------------------------------------------
package mesh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_e;

    // PE opcodes; the sequencer forwards these untouched.
    localparam logic [3:0] OP_FADD = 4'd0;
    localparam logic [3:0] OP_FMUL = 4'd1;
    localparam logic [3:0] OP_SFMA = 4'd2;
    localparam logic [3:0] OP_FMA  = 4'd3;

    localparam int CLEAR_CYCLES_DEF = 2;
    localparam int PIPE_DEPTH_DEF   = 2;
    localparam int CNT_W            = 16;

endpackage

// File: rtl/mesh_config_sequencer_if.sv
// ----------------------------------------------------------------------------
// mesh_config_sequencer_if
// Configuration beat channel (valid/ready handshake) into the sequencer.
//   cfg_valid  : beat valid (master -> slave)
//   cfg_ready  : sequencer accepts beat (slave -> master)
//   cfg_pe     : target PE index
//   cfg_instr  : PE instruction
//   cfg_data   : PE internal register value
//   cfg_last   : final beat of the program
// ----------------------------------------------------------------------------
interface mesh_config_sequencer_if #(
    parameter int NUM_PE = 16
);
    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [PE_W-1:0] cfg_pe;
    logic [3:0]      cfg_instr;
    logic [31:0]     cfg_data;
    logic            cfg_last;

    modport master (
        output cfg_valid, cfg_pe, cfg_instr, cfg_data, cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pe, cfg_instr, cfg_data, cfg_last,
        output cfg_ready
    );

endinterface

// File: rtl/mesh_config_sequencer_seq_counter.sv
// ----------------------------------------------------------------------------
// seq_counter
// Loadable down-counter with zero flag; times the CLEAR, RUN and DRAIN phases.
//   clk, reset_n : clock, async active-low reset
//   load         : load load_val (has priority over dec)
//   dec          : decrement; holds at zero instead of wrapping
//   load_val     : value to load
//   zero         : count is zero
// ----------------------------------------------------------------------------
module seq_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mesh_config_sequencer.sv
// ----------------------------------------------------------------------------
// mesh_config_sequencer
// Sequences a PE mesh through clear, per-PE configuration load, a timed run
// and a pipeline drain.
//   clk, reset_n   : clock, async active-low reset
//   cfg_start      : begin a sequence (honoured only in IDLE)
//   run_len        : compute cycles, latched when cfg_start is accepted
//   cfg            : config beat channel (slave side)
//   pe_reset       : synchronous clear broadcast to all PEs
//   pe_load        : one-hot per-PE load strobe
//   pe_instruction : broadcast instruction (holds last loaded value)
//   pe_data        : broadcast register value (holds last loaded value)
//   run_active     : mesh computing
//   busy           : sequencer not idle
//   done, err      : one-cycle pulses: sequence complete / out-of-range PE
//
// state  | meaning
// IDLE   | waiting for cfg_start
// CLEAR  | pe_reset held for CLEAR_CYCLES cycles
// LOAD   | accepting config beats until the last one has been strobed
// RUN    | run_active held for the latched run_len cycles
// DRAIN  | PIPE_DEPTH cycles for the PE pipeline to empty, then done
// ----------------------------------------------------------------------------
module mesh_config_sequencer
    import mesh_pkg::*;
#(
    parameter int NUM_PE       = 16,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
    parameter int PIPE_DEPTH   = PIPE_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_start,
    input  logic [15:0]              run_len,
    mesh_config_sequencer_if.slave   cfg,
    output logic                     pe_reset,
    output logic [NUM_PE-1:0]        pe_load,
    output logic [3:0]               pe_instruction,
    output logic [31:0]              pe_data,
    output logic                     run_active,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [CNT_W-1:0]  CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRN_LOAD = CNT_W'(PIPE_DEPTH - 1);
    localparam logic [NUM_PE-1:0] PE_ONE   = NUM_PE'(1);

    seq_state_e       state;
    logic [15:0]      run_len_q;
    logic             cfg_ready_q;
    logic             last_pending;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             hs;
    logic             pe_in_range;

    assign cfg.cfg_ready = cfg_ready_q;
    assign hs            = cfg.cfg_valid & cfg_ready_q;
    // Only reachable as false when NUM_PE is not a power of two.
    assign pe_in_range   = (int'(cfg.cfg_pe) < NUM_PE);

    // Counters are loaded with length-1 so the phase lasts exactly length
    // cycles: the exit test happens in the cycle the count reads zero.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    cnt_load = 1'b1;
                    cnt_val  = CLR_LOAD;
                end
            end
            ST_CLEAR: cnt_dec = 1'b1;
            ST_LOAD: begin
                if (last_pending) begin
                    cnt_load = 1'b1;
                    cnt_val  = (run_len_q != 16'd0) ? (run_len_q - 16'd1) : DRN_LOAD;
                end
            end
            ST_RUN: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = DRN_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DRAIN: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    seq_counter #(.W(CNT_W)) u_seq_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            run_len_q      <= '0;
            cfg_ready_q    <= 1'b0;
            last_pending   <= 1'b0;
            pe_reset       <= 1'b0;
            pe_load        <= '0;
            pe_instruction <= '0;
            pe_data        <= '0;
            run_active     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            pe_load <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        run_len_q <= run_len;
                        pe_reset  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_zero) begin
                        pe_reset    <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Stay in LOAD for the cycle the final strobe is visible so
                    // pe_load never overlaps RUN.
                    if (last_pending) begin
                        last_pending <= 1'b0;
                        if (run_len_q != 16'd0) begin
                            run_active <= 1'b1;
                            state      <= ST_RUN;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (hs) begin
                        if (pe_in_range) begin
                            pe_load        <= PE_ONE << cfg.cfg_pe;
                            pe_instruction <= cfg.cfg_instr;
                            pe_data        <= cfg.cfg_data;
                        end else begin
                            err <= 1'b1;
                        end
                        if (cfg.cfg_last) begin
                            cfg_ready_q  <= 1'b0;
                            last_pending <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_zero) begin
                        run_active <= 1'b0;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_zero) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_config_sequencer.sv
// Directed bench; NUM_PE=12 so that out-of-range PE indices are encodable
// in the 4-bit cfg_pe field.
module tb_mesh_config_sequencer;
    import mesh_pkg::*;

    localparam int NUM_PE = 12;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cfg_start;
    logic [15:0]       run_len;
    logic              pe_reset;
    logic [NUM_PE-1:0] pe_load;
    logic [3:0]        pe_instruction;
    logic [31:0]       pe_data;
    logic              run_active;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    mesh_config_sequencer_if #(.NUM_PE(NUM_PE)) cfg_if ();

    mesh_config_sequencer #(
        .NUM_PE       (NUM_PE),
        .CLEAR_CYCLES (2),
        .PIPE_DEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start      (cfg_start),
        .run_len        (run_len),
        .cfg            (cfg_if.slave),
        .pe_reset       (pe_reset),
        .pe_load        (pe_load),
        .pe_instruction (pe_instruction),
        .pe_data        (pe_data),
        .run_active     (run_active),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pe_load and pe_reset must never overlap.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checks++;
            assert (!(pe_reset && (pe_load != '0))) else begin
                errors++;
                $error("FAIL load_reset_overlap observed=%0h expected=0", pe_load);
            end
        end
    end

    task automatic beat(input logic v, input logic [3:0] pe, input logic [3:0] instr,
                        input logic [31:0] data, input logic last);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_pe    = pe;
        cfg_if.cfg_instr = instr;
        cfg_if.cfg_data  = data;
        cfg_if.cfg_last  = last;
    endtask

    bit         tv [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] tp [8] = '{4'd0, 4'd0, 4'd3, 4'd7, 4'd1, 4'd9, 4'd4, 4'd10};

    initial begin
        reset_n   = 1'b0;
        cfg_start = 1'b0;
        run_len   = 16'd0;
        beat(1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_pe_reset", pe_reset, 0);
        chk("rst_pe_load", pe_load, 0);
        chk("rst_run_active", run_active, 0);
        chk("rst_cfg_ready", cfg_if.cfg_ready, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Basic sequence: two beats, run_len=3; cfg_start and run_len poked mid-run.
        cfg_start = 1'b1;
        run_len   = 16'd3;
        tick();
        chk("clr1_pe_reset", pe_reset, 1);
        chk("clr1_busy", busy, 1);
        chk("clr1_cfg_ready", cfg_if.cfg_ready, 0);
        cfg_start = 1'b0;
        tick();
        chk("clr2_pe_reset", pe_reset, 1);
        tick();
        chk("clr_end_pe_reset", pe_reset, 0);
        chk("load_cfg_ready", cfg_if.cfg_ready, 1);
        beat(1'b1, 4'd2, OP_FMUL, 32'h3F80_0000, 1'b0);
        tick();
        chk("b1_pe_load", pe_load, 32'h004);
        chk("b1_instr", pe_instruction, 1);
        chk("b1_data", pe_data, 32'h3F80_0000);
        beat(1'b1, 4'd5, OP_FMA, 32'h4000_0000, 1'b1);
        tick();
        chk("b2_pe_load", pe_load, 32'h020);
        chk("b2_instr", pe_instruction, 3);
        chk("b2_data", pe_data, 32'h4000_0000);
        chk("b2_cfg_ready", cfg_if.cfg_ready, 0);
        chk("b2_run_active", run_active, 0);
        beat(1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
        tick();
        chk("run1_active", run_active, 1);
        chk("run1_pe_load", pe_load, 0);
        cfg_start = 1'b1;
        run_len   = 16'd9;
        tick();
        chk("run2_active", run_active, 1);
        cfg_start = 1'b0;
        tick();
        chk("run3_active", run_active, 1);
        tick();
        chk("drn1_active", run_active, 0);
        chk("drn1_done", done, 0);
        chk("drn1_busy", busy, 1);
        tick();
        chk("drn2_active", run_active, 0);
        chk("drn2_done", done, 0);
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        tick();
        chk("done_clear", done, 0);
        chk("idle_no_restart", pe_reset, 0);
        chk("hold_instr", pe_instruction, 3);
        chk("hold_data", pe_data, 32'h4000_0000);

        // run_len=0, out-of-range beat, toggled valid.
        cfg_start = 1'b1;
        run_len   = 16'd0;
        tick();
        chk("t2_clr", pe_reset, 1);
        cfg_start = 1'b0;
        tick();
        tick();
        chk("t2_ready", cfg_if.cfg_ready, 1);
        beat(1'b1, 4'd14, OP_SFMA, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("oor_err", err, 1);
        chk("oor_pe_load", pe_load, 0);
        chk("oor_data_hold", pe_data, 32'h4000_0000);
        chk("oor_ready", cfg_if.cfg_ready, 1);
        beat(1'b1, 4'd11, OP_SFMA, 32'h1234_5678, 1'b0);
        tick();
        chk("after_oor_err", err, 0);
        chk("after_oor_load", pe_load, 32'h800);
        chk("sfma_instr", pe_instruction, 2);
        chk("after_oor_data", pe_data, 32'h1234_5678);
        for (int i = 0; i < 8; i++) begin
            cfg_if.cfg_valid = tv[i];
            cfg_if.cfg_pe    = tp[i];
            tick();
            chk("toggle_pe_load", pe_load, tv[i] ? (32'd1 << tp[i]) : 32'd0);
        end
        beat(1'b1, 4'd0, OP_FADD, 32'h0000_0001, 1'b1);
        tick();
        chk("t2_last_load", pe_load, 32'h001);
        chk("t2_last_ready", cfg_if.cfg_ready, 0);
        beat(1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
        tick();
        chk("t2_d1_active", run_active, 0);
        chk("t2_d1_load", pe_load, 0);
        chk("t2_d1_done", done, 0);
        tick();
        chk("t2_d2_active", run_active, 0);
        chk("t2_d2_done", done, 0);
        tick();
        chk("t2_done", done, 1);

        // Reset asserted in the middle of RUN.
        tick();
        cfg_start = 1'b1;
        run_len   = 16'd5;
        tick();
        cfg_start = 1'b0;
        tick();
        tick();
        beat(1'b1, 4'd3, OP_FMUL, 32'hAAAA_5555, 1'b1);
        tick();
        chk("t3_load", pe_load, 32'h008);
        beat(1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
        tick();
        chk("t3_run1", run_active, 1);
        tick();
        chk("t3_run2", run_active, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_run_active", run_active, 0);
        chk("rst_run_busy", busy, 0);
        chk("rst_run_pe_load", pe_load, 0);
        chk("rst_run_pe_data", pe_data, 0);
        chk("rst_run_instr", pe_instruction, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", done, 0);
        end
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        cfg_start = 1'b1;
        run_len   = 16'd1;
        tick();
        chk("post_rst_clear", pe_reset, 1);
        chk("post_rst_ready", cfg_if.cfg_ready, 0);
        cfg_start = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
